// File: rtl/ccm_coef_bank.sv
// Double-buffered 3x3 colour-matrix coefficient store: writes land in a shadow
// bank and are copied to the active bank on the first frame_start after commit.
module ccm_coef_bank #(
   parameter int MDW         = 16,
   parameter int UNITY_SHIFT = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [3:0]       wr_addr,
   input  logic [MDW-1:0]   wr_data,
   input  logic             commit,
   input  logic             frame_start,
   output logic [9*MDW-1:0] matrix,
   output logic             pending,
   output logic             swap_done,
   output logic             wr_err,
   output logic             dirty
);

   typedef enum logic {IDLE, ARMED} state_t;

   localparam logic [MDW-1:0] UNITY = {{(MDW-1){1'b0}}, 1'b1} << UNITY_SHIFT;

   state_t         state_q, state_d;
   logic [MDW-1:0] shadow_q [9];
   logic [MDW-1:0] active_q [9];
   logic           wr_fire;
   logic           addr_ok;
   logic           do_swap;

   function automatic logic [MDW-1:0] identity_at(input int k);
      return (k == 0 || k == 4 || k == 8) ? UNITY : '0;
   endfunction

   // Writes are only accepted while IDLE so the shadow is frozen once armed.
   assign wr_fire   = wr_valid && (state_q == IDLE);
   assign addr_ok   = (wr_addr <= 4'd8);
   assign wr_ready  = (state_q == IDLE);
   assign pending   = (state_q == ARMED);

   always_comb begin
      state_d = state_q;
      do_swap = 1'b0;
      case (state_q)
         IDLE:  if (commit) state_d = ARMED;
         ARMED: if (frame_start) begin
                   state_d = IDLE;
                   do_swap = 1'b1;
                end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         dirty     <= 1'b0;
         wr_err    <= 1'b0;
         swap_done <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            shadow_q[k] <= identity_at(k);
            active_q[k] <= identity_at(k);
         end
      end else begin
         state_q   <= state_d;
         wr_err    <= wr_fire && !addr_ok;
         swap_done <= do_swap;
         if (do_swap) begin
            dirty <= 1'b0;
         end else if (wr_fire && addr_ok) begin
            dirty <= 1'b1;
         end
         // All nine entries move together so the multiplier never sees a mixed matrix.
         for (int k = 0; k < 9; k++) begin
            if (wr_fire && wr_addr == 4'(k)) begin
               shadow_q[k] <= wr_data;
            end
            if (do_swap) begin
               active_q[k] <= shadow_q[k];
            end
         end
      end
   end

   always_comb begin
      matrix = '0;
      for (int k = 0; k < 9; k++) begin
         matrix[k*MDW +: MDW] = active_q[k];
      end
   end

endmodule

// File: tb/tb_ccm_coef_bank.sv
// Self-checking bench for ccm_coef_bank: directed test-plan scenarios with literal
// expectations, then randomized traffic compared every cycle against a bank-level model.
module tb_ccm_coef_bank;

   localparam int MDW = 16;

   logic             clk = 1'b0;
   logic             rstn = 1'b1;
   logic             wr_valid = 1'b0;
   logic             wr_ready;
   logic [3:0]       wr_addr = '0;
   logic [MDW-1:0]   wr_data = '0;
   logic             commit = 1'b0;
   logic             frame_start = 1'b0;
   logic [9*MDW-1:0] matrix;
   logic             pending;
   logic             swap_done;
   logic             wr_err;
   logic             dirty;

   int checks = 0;
   int failures = 0;
   bit checkEn = 1'b0;

   logic [MDW-1:0] mShadow [9];
   logic [MDW-1:0] mActive [9];
   bit mPending, mDirty, mSwap, mErr;

   ccm_coef_bank #(.MDW(MDW), .UNITY_SHIFT(8)) dut (
      .clk(clk), .rstn(rstn),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .frame_start(frame_start),
      .matrix(matrix), .pending(pending), .swap_done(swap_done),
      .wr_err(wr_err), .dirty(dirty)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [9*MDW-1:0] actual,
                              input logic [9*MDW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 9; k++) begin
         mShadow[k] = (k == 0 || k == 4 || k == 8) ? 16'd256 : 16'd0;
         mActive[k] = mShadow[k];
      end
      mPending = 0; mDirty = 0; mSwap = 0; mErr = 0;
   endtask

   // One clock edge of the bank's behaviour, expressed over whole banks.
   task automatic modelStep();
      mSwap = 0;
      mErr  = 0;
      if (!mPending) begin
         if (wr_valid) begin
            if (wr_addr < 4'd9) begin
               mShadow[wr_addr] = wr_data;
               mDirty = 1;
            end else begin
               mErr = 1;
            end
         end
         if (commit) mPending = 1;
      end else if (frame_start) begin
         mActive  = mShadow;
         mDirty   = 0;
         mPending = 0;
         mSwap    = 1;
      end
   endtask

   function automatic logic [9*MDW-1:0] modelMatrix();
      logic [9*MDW-1:0] m;
      for (int k = 0; k < 9; k++) m[k*MDW +: MDW] = mActive[k];
      return m;
   endfunction

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("matrix",    matrix,    modelMatrix());
         checkOutput("wr_ready",  {143'd0, wr_ready},  {143'd0, !mPending});
         checkOutput("pending",   {143'd0, pending},   {143'd0, mPending});
         checkOutput("swap_done", {143'd0, swap_done}, {143'd0, mSwap});
         checkOutput("wr_err",    {143'd0, wr_err},    {143'd0, mErr});
         checkOutput("dirty",     {143'd0, dirty},     {143'd0, mDirty});
      end
   end

   task automatic applyStimulus(input bit v, input logic [3:0] a, input logic [MDW-1:0] d,
                                input bit c, input bit f);
      wr_valid = v; wr_addr = a; wr_data = d; commit = c; frame_start = f;
      @(posedge clk);
      if (rstn) modelStep();
      @(negedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 4'd0, '0, 0, 0);
   endtask

   task automatic resetPulse(input int n);
      rstn = 1'b0;
      modelReset();
      checkEn = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      #2;
      rstn = 1'b1;
   endtask

   function automatic logic [9*MDW-1:0] entry(input int k);
      return {128'd0, matrix[k*MDW +: MDW]};
   endfunction

   initial begin
      @(negedge clk);
      #2;
      resetPulse(2);
      idle(5);
      checkOutput("lit_reset_e0", entry(0), 144'd256);
      checkOutput("lit_reset_e1", entry(1), 144'd0);
      checkOutput("lit_reset_e8", entry(8), 144'd256);
      checkOutput("lit_reset_ready", {143'd0, wr_ready}, 144'd1);

      // Fill shadow with 1..9, commit, swap ten cycles later.
      for (int k = 0; k < 9; k++) applyStimulus(1, 4'(k), 16'(k + 1), 0, 0);
      applyStimulus(0, 4'd0, '0, 1, 0);
      idle(10);
      checkOutput("lit_preswap_e0", entry(0), 144'd256);
      checkOutput("lit_preswap_dirty", {143'd0, dirty}, 144'd1);
      applyStimulus(0, 4'd0, '0, 0, 1);
      checkOutput("lit_swap_pulse", {143'd0, swap_done}, 144'd1);
      checkOutput("lit_swap_e5", entry(5), 144'd6);
      checkOutput("lit_swap_dirty", {143'd0, dirty}, 144'd0);
      idle(1);
      checkOutput("lit_swap_pulse_end", {143'd0, swap_done}, 144'd0);

      // Writes stall while armed; the held write lands in shadow only after the swap.
      applyStimulus(0, 4'd0, '0, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 4'd3, 16'hFFFB, 0, 0);
      checkOutput("lit_armed_ready", {143'd0, wr_ready}, 144'd0);
      applyStimulus(1, 4'd3, 16'hFFFB, 0, 1);
      checkOutput("lit_armed_e3", entry(3), 144'd4);
      applyStimulus(1, 4'd3, 16'hFFFB, 0, 0);
      idle(1);
      checkOutput("lit_late_write_e3", entry(3), 144'd4);
      checkOutput("lit_late_write_dirty", {143'd0, dirty}, 144'd1);

      // Illegal address then most-negative coefficient.
      applyStimulus(1, 4'd12, 16'h1234, 0, 0);
      checkOutput("lit_wr_err", {143'd0, wr_err}, 144'd1);
      applyStimulus(1, 4'd2, 16'h8000, 1, 0);
      checkOutput("lit_wr_err_end", {143'd0, wr_err}, 144'd0);
      applyStimulus(0, 4'd0, '0, 0, 1);
      checkOutput("lit_min_e2", entry(2), 144'h8000);

      // commit together with frame_start only arms.
      applyStimulus(1, 4'd0, 16'h0077, 1, 1);
      checkOutput("lit_cf_pending", {143'd0, pending}, 144'd1);
      checkOutput("lit_cf_noswap", entry(0), 144'd1);
      applyStimulus(0, 4'd0, '0, 0, 1);
      checkOutput("lit_cf_swap", entry(0), 144'h77);

      // Reset while armed with a dirty shadow.
      applyStimulus(1, 4'd4, 16'h0042, 1, 0);
      resetPulse(1);
      checkOutput("lit_rst_e4", entry(4), 144'd256);
      checkOutput("lit_rst_pending", {143'd0, pending}, 144'd0);
      applyStimulus(0, 4'd0, '0, 0, 1);
      checkOutput("lit_rst_noswap", {143'd0, swap_done}, 144'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            resetPulse($urandom_range(1, 2));
         end else begin
            applyStimulus($urandom_range(0, 1) == 1,
                          ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15))
                                                      : 4'($urandom_range(0, 8)),
                          16'($urandom),
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 7) == 0);
         end
      end

      idle(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
